// File: rtl/sum_diff_sequencer.sv
// Evaluates (a + b) < (c - d) on 4-bit unsigned operands with one shared adder,
// stepping through ADD, SUB and CMP. A start/done handshake sequences each request.

module sds_adder4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   assign {cout, s} = {1'b0, x} + {1'b0, y} + {4'b0, cin};
endmodule

module sum_diff_sequencer (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] c,
   input  logic [3:0] d,
   output logic       busy,
   output logic       done,
   output logic       out,
   output logic [3:0] sum,
   output logic [3:0] diff,
   output logic       carry,
   output logic       borrow
);
   typedef enum logic [2:0] {IDLE, ADD, SUB, CMP, DONE} state_t;

   state_t     state, state_nxt;
   logic [3:0] ra, rb, rc, rd;
   logic [3:0] ax, ay, as;
   logic       acin, acout;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = ADD;
         ADD:  begin busy = 1'b1; state_nxt = SUB;  end
         SUB:  begin busy = 1'b1; state_nxt = CMP;  end
         CMP:  begin busy = 1'b1; state_nxt = DONE; end
         DONE: begin done = 1'b1; state_nxt = IDLE; end
         default: state_nxt = IDLE;
      endcase
   end

   // Subtraction reuses the adder as c + ~d + 1; carry-out low means borrow.
   always_comb begin
      ax   = ra;
      ay   = rb;
      acin = 1'b0;
      if (state == SUB) begin
         ax   = rc;
         ay   = ~rd;
         acin = 1'b1;
      end
   end

   sds_adder4 u_add (.x(ax), .y(ay), .cin(acin), .s(as), .cout(acout));

   always_ff @(posedge clock) begin
      if (reset) begin
         ra     <= 4'd0;
         rb     <= 4'd0;
         rc     <= 4'd0;
         rd     <= 4'd0;
         sum    <= 4'd0;
         diff   <= 4'd0;
         carry  <= 1'b0;
         borrow <= 1'b0;
         out    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               ra <= a;
               rb <= b;
               rc <= c;
               rd <= d;
            end
            ADD: begin
               sum   <= as;
               carry <= acout;
            end
            SUB: begin
               diff   <= as;
               borrow <= ~acout;
            end
            CMP:     out <= (sum < diff);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sum_diff_sequencer.sv
// Directed bench for sum_diff_sequencer: latency, arithmetic wrap cases,
// held-start handshake and reset abort behaviour.

module tb_sum_diff_sequencer;
   logic       clock = 1'b0;
   logic       reset, start;
   logic [3:0] a, b, c, d;
   logic       busy, done, out, carry, borrow;
   logic [3:0] sum, diff;

   int n_cmp = 0;
   int n_err = 0;

   sum_diff_sequencer dut (
      .clock(clock), .reset(reset), .start(start),
      .a(a), .b(b), .c(c), .d(d),
      .busy(busy), .done(done), .out(out),
      .sum(sum), .diff(diff), .carry(carry), .borrow(borrow)
   );

   always #5 clock = ~clock;

   // One request; operands are scrambled right after acceptance.
   task automatic do_op(input logic [3:0] ia, ib, ic, id,
                        output int lat, output int nbusy, output int ndone,
                        output int overlap);
      lat = 0; nbusy = 0; ndone = 0; overlap = 0;
      @(negedge clock);
      a = ia; b = ib; c = ic; d = id; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      a = ~ia; b = ~ib; c = ~ic; d = ~id;
      for (int i = 1; i <= 8; i++) begin
         if (i > 1) @(negedge clock);
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (lat == 0) lat = i;
         end
         if (busy && done) overlap++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0; c = 4'd0; d = 4'd0;
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({busy, done, out, carry, borrow, sum, diff} !== 13'd0) begin
         n_err++;
         $display("FAIL reset_state: got busy=%b done=%b out=%b carry=%b borrow=%b sum=%0d diff=%0d, want all 0",
                  busy, done, out, carry, borrow, sum, diff);
      end
      reset = 1'b0;
   endtask

   task automatic test_vec(input string nm, input logic [3:0] ia, ib, ic, id,
                           input logic [3:0] es, ed, input logic ec, eb, eo);
      int lat, nb, nd, ov;
      do_op(ia, ib, ic, id, lat, nb, nd, ov);
      n_cmp++;
      if (lat !== 4 || nb !== 3 || nd !== 1 || ov !== 0) begin
         n_err++;
         $display("FAIL %s_timing: got lat=%0d busy=%0d dones=%0d overlap=%0d, want 4/3/1/0",
                  nm, lat, nb, nd, ov);
      end
      n_cmp++;
      if (sum !== es || diff !== ed || carry !== ec || borrow !== eb || out !== eo) begin
         n_err++;
         $display("FAIL %s_result: got sum=%0d diff=%0d carry=%b borrow=%b out=%b, want %0d %0d %b %b %b",
                  nm, sum, diff, carry, borrow, out, es, ed, ec, eb, eo);
      end
   endtask

   task automatic test_handshake();
      int bad_done = 0;
      for (int n = 0; n <= 17; n++) begin
         @(negedge clock);
         if (n >= 1) begin
            if (done !== (n == 4 || n == 9 || n == 14)) bad_done++;
            if (n == 4) begin
               n_cmp++;
               if (sum !== 4'd10 || diff !== 4'd7 || carry !== 1'b0 || borrow !== 1'b0 || out !== 1'b0) begin
                  n_err++;
                  $display("FAIL hs_first: got sum=%0d diff=%0d carry=%b borrow=%b out=%b, want 10 7 0 0 0",
                           sum, diff, carry, borrow, out);
               end
            end
            if (n == 9) begin
               n_cmp++;
               if (sum !== 4'd1 || diff !== 4'd14 || carry !== 1'b1 || borrow !== 1'b1 || out !== 1'b1) begin
                  n_err++;
                  $display("FAIL hs_second: got sum=%0d diff=%0d carry=%b borrow=%b out=%b, want 1 14 1 1 1",
                           sum, diff, carry, borrow, out);
               end
            end
            if (n == 14) begin
               n_cmp++;
               if (sum !== 4'd2 || diff !== 4'd0 || out !== 1'b0) begin
                  n_err++;
                  $display("FAIL hs_third: got sum=%0d diff=%0d out=%b, want 2 0 0", sum, diff, out);
               end
            end
         end
         start = (n < 12);
         case (n)
            0:  begin a = 4'd6; b = 4'd4; c = 4'd9; d = 4'd2; end
            5:  begin a = 4'd8; b = 4'd9; c = 4'd2; d = 4'd4; end
            10: begin a = 4'd1; b = 4'd1; c = 4'd1; d = 4'd1; end
            default: begin
               a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
            end
         endcase
      end
      n_cmp++;
      if (bad_done !== 0) begin
         n_err++;
         $display("FAIL hs_done_pattern: got %0d wrong done cycles, want 0", bad_done);
      end
   endtask

   task automatic test_reset_mid();
      int lat, nb, nd, ov, stray;
      do_op(4'd0, 4'd0, 4'd1, 4'd0, lat, nb, nd, ov); // leaves out=1
      @(negedge clock);
      a = 4'd5; b = 4'd6; c = 4'd10; d = 4'd9; start = 1'b1;
      @(negedge clock);                 // ADD
      start = 1'b0;
      @(negedge clock);                 // SUB
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || out !== 1'b0 || sum !== 4'd0 || diff !== 4'd0) begin
         n_err++;
         $display("FAIL reset_mid: got busy=%b done=%b out=%b sum=%0d diff=%0d, want 0 0 0 0 0",
                  busy, done, out, sum, diff);
      end
      stray = 0;
      repeat (6) begin
         @(negedge clock);
         if (done || busy) stray++;
      end
      n_cmp++;
      if (stray !== 0) begin
         n_err++;
         $display("FAIL reset_mid_no_done: got %0d busy/done cycles, want 0", stray);
      end
      // reset and start together: start must be dropped
      a = 4'd15; b = 4'd1; c = 4'd5; d = 4'd0;
      reset = 1'b1; start = 1'b1;
      @(negedge clock);
      reset = 1'b0; start = 1'b0;
      stray = 0;
      repeat (6) begin
         if (done || busy) stray++;
         @(negedge clock);
      end
      n_cmp++;
      if (stray !== 0 || sum !== 4'd0) begin
         n_err++;
         $display("FAIL reset_start_same_edge: got %0d busy/done cycles sum=%0d, want 0 and 0", stray, sum);
      end
   endtask

   initial begin
      test_reset();
      test_vec("basic",     4'd5,  4'd6, 4'd10, 4'd9, 4'd11, 4'd1,  1'b0, 1'b0, 1'b0);
      test_vec("min_true",  4'd0,  4'd0, 4'd1,  4'd0, 4'd0,  4'd1,  1'b0, 1'b0, 1'b1);
      test_vec("min_false", 4'd1,  4'd0, 4'd0,  4'd0, 4'd1,  4'd0,  1'b0, 1'b0, 1'b0);
      test_vec("sum_wrap",  4'd15, 4'd1, 4'd5,  4'd0, 4'd0,  4'd5,  1'b1, 1'b0, 1'b1);
      test_vec("equal",     4'd15, 4'd0, 4'd15, 4'd0, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
      test_vec("diff_wrap", 4'd0,  4'd0, 4'd0,  4'd1, 4'd0,  4'd15, 1'b0, 1'b1, 1'b1);
      test_handshake();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
